// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_muldiv_seq_if : request/result handshake and shared-ALU port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic            sign;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_sel;
   logic [XLEN-1:0] alu_res;

   modport master (
      output start, op, sign, src_a, src_b, flush, alu_res,
      input  busy, done, result, alu_a, alu_b, alu_sel
   );

   modport slave (
      input  start, op, sign, src_a, src_b, flush, alu_res,
      output busy, done, result, alu_a, alu_b, alu_sel
   );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_muldiv_seq : RV32M mul/div sequencer, one shared-ALU ADD/SUB per cycle.
// Define MULDIV_SIGNED_EN for signed MULH/DIV/REM.            Rev 1.0
// ----------------------------------------------------------------------------
module alu_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   alu_muldiv_seq_if.slave bus
);

   localparam logic [3:0] ALU_ADD  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
`ifdef MULDIV_SIGNED_EN
   localparam logic [3:0] ALU_PASS = 4'b0110;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      DONE     = 3'd2,
      SIGN_IN  = 3'd3,
      SIGN_OUT = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
`endif

   state_t            state, state_nx;
   // acc holds hi (multiply) or rem (divide); low holds lo or quo; opd holds mcand or divisor
   logic [XLEN-1:0]   acc, acc_nx;
   logic [XLEN-1:0]   low, low_nx;
   logic [XLEN-1:0]   opd, opd_nx;
   logic [XLEN-1:0]   result_q, result_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [1:0]        op_q, op_nx;
   logic [XLEN-1:0]   alu_a, alu_b, shifted;
   logic [3:0]        alu_sel;
   logic              carry, take;
`ifdef MULDIV_SIGNED_EN
   logic              sgn, sgn_nx, sa, sa_nx, sb, sb_nx, phase, phase_nx;
   logic [XLEN-1:0]   operand;
   logic              neg;
`else
   logic              unused_sign;
   assign unused_sign = bus.sign;
`endif

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      low_nx    = low;
      opd_nx    = opd;
      cnt_nx    = cnt;
      op_nx     = op_q;
      result_nx = result_q;
      alu_a     = '0;
      alu_b     = '0;
      alu_sel   = ALU_ADD;
      shifted   = {acc[XLEN-2:0], low[XLEN-1]};
      carry     = 1'b0;
      take      = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_nx    = sgn;
      sa_nx     = sa;
      sb_nx     = sb;
      phase_nx  = phase;
      operand   = '0;
      neg       = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               // op[1] selects divide; op[0] selects the upper/remainder word
               op_nx  = bus.op;
               acc_nx = '0;
               cnt_nx = '0;
               low_nx = bus.op[1] ? bus.src_a : bus.src_b;
               opd_nx = bus.op[1] ? bus.src_b : bus.src_a;
               if (bus.op[1] && bus.src_b == '0) begin
                  acc_nx   = bus.src_a;
                  low_nx   = '1;
                  state_nx = DONE;
               end else begin
`ifdef MULDIV_SIGNED_EN
                  sgn_nx   = bus.sign && (bus.op != 2'b00);
                  sa_nx    = bus.src_a[XLEN-1];
                  sb_nx    = bus.src_b[XLEN-1];
                  phase_nx = 1'b0;
                  state_nx = sgn_nx ? SIGN_IN : RUN;
`else
                  state_nx = RUN;
`endif
               end
            end
         end
         RUN: begin
            if (!op_q[1]) begin
               alu_a  = acc;
               alu_b  = low[0] ? opd : '0;
               carry  = bus.alu_res < acc;
               acc_nx = {carry, bus.alu_res[XLEN-1:1]};
               low_nx = {bus.alu_res[0], low[XLEN-1:1]};
            end else begin
               alu_sel = ALU_SUB;
               alu_a   = shifted;
               alu_b   = opd;
               take    = acc[XLEN-1] || (shifted >= opd);
               acc_nx  = take ? bus.alu_res : shifted;
               low_nx  = {low[XLEN-2:0], take};
            end
            cnt_nx = cnt + 1'b1;
            if (cnt == '1) begin
`ifdef MULDIV_SIGNED_EN
               phase_nx = 1'b0;
               state_nx = sgn ? SIGN_OUT : DONE;
`else
               state_nx = DONE;
`endif
            end
            if (bus.flush) state_nx = IDLE;
         end
`ifdef MULDIV_SIGNED_EN
         SIGN_IN: begin
            operand = phase ? opd : low;
            if (operand[XLEN-1]) begin
               alu_sel = ALU_SUB;
               alu_b   = operand;
            end else begin
               alu_sel = ALU_PASS;
               alu_b   = operand;
            end
            if (phase) opd_nx = bus.alu_res;
            else       low_nx = bus.alu_res;
            phase_nx = ~phase;
            if (phase) state_nx = RUN;
            if (bus.flush) state_nx = IDLE;
         end
         SIGN_OUT: begin
            // Phase 0 fixes lo/quo, phase 1 fixes hi (64-bit carry-in from lo==0) or rem
            if (!phase) begin
               neg     = sa ^ sb;
               alu_sel = neg ? ALU_SUB : ALU_PASS;
               alu_b   = low;
               low_nx  = bus.alu_res;
            end else if (!op_q[1]) begin
               neg     = sa ^ sb;
               alu_sel = neg ? ALU_ADD : ALU_PASS;
               alu_a   = neg ? ~acc : '0;
               alu_b   = neg ? {{(XLEN-1){1'b0}}, low == '0} : acc;
               acc_nx  = bus.alu_res;
            end else begin
               neg     = sa;
               alu_sel = neg ? ALU_SUB : ALU_PASS;
               alu_b   = acc;
               acc_nx  = bus.alu_res;
            end
            phase_nx = ~phase;
            if (phase) state_nx = DONE;
            if (bus.flush) state_nx = IDLE;
         end
`endif
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (state_nx == DONE && state != DONE) begin
         result_nx = op_nx[0] ? acc_nx : low_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         low      <= '0;
         opd      <= '0;
         result_q <= '0;
         cnt      <= '0;
         op_q     <= '0;
`ifdef MULDIV_SIGNED_EN
         sgn      <= 1'b0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         phase    <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         acc      <= acc_nx;
         low      <= low_nx;
         opd      <= opd_nx;
         result_q <= result_nx;
         cnt      <= cnt_nx;
         op_q     <= op_nx;
`ifdef MULDIV_SIGNED_EN
         sgn      <= sgn_nx;
         sa       <= sa_nx;
         sb       <= sb_nx;
         phase    <= phase_nx;
`endif
      end
   end

   assign bus.busy    = (state != IDLE) && (state != DONE);
   assign bus.done    = (state == DONE);
   assign bus.result  = result_q;
   assign bus.alu_a   = alu_a;
   assign bus.alu_b   = alu_b;
   assign bus.alu_sel = alu_sel;

endmodule
`default_nettype wire
